// File: rtl/loopback_checker.sv
// PRBS-style counter loopback checker: finds bit alignment by rotating the received word,
// locks on a run of consecutive +/-1 steps, then counts words and errors while locked.
module loopback_checker #(
  parameter int DATA_W     = 8,
  parameter int MODE       = 0,
  parameter int LOCK_CNT   = 16,
  parameter int SLIP_LIM   = 8,
  parameter int UNLOCK_ERR = 4,
  parameter int CNT_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      rx_valid,
  input  logic [DATA_W-1:0]         rx_data,
  output logic                      locked,
  output logic [$clog2(DATA_W)-1:0] slip_sel,
  output logic                      err_pulse,
  output logic [CNT_W-1:0]          err_count,
  output logic [CNT_W-1:0]          word_count
);

  localparam int SLIP_W = $clog2(DATA_W);
  localparam int RUN_W  = 16;

  typedef enum logic [1:0] {StIdle, StSearch, StLocked} state_e;

  state_e              state;
  logic [DATA_W-1:0]   prev;
  logic                seeded;
  logic [RUN_W-1:0]    match_run;
  logic [RUN_W-1:0]    miss_run;
  logic [RUN_W-1:0]    err_run;

  logic [2*DATA_W-1:0] dbl;
  logic [DATA_W-1:0]   aligned;
  logic [DATA_W-1:0]   expected;
  logic                match;

  always_comb begin
    dbl      = {rx_data, rx_data} >> slip_sel;
    aligned  = dbl[DATA_W-1:0];
    expected = (MODE == 0) ? prev + DATA_W'(1) : prev - DATA_W'(1);
    match    = (aligned == expected);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      slip_sel   <= '0;
      err_count  <= '0;
      word_count <= '0;
      prev       <= '0;
      seeded     <= 1'b0;
      match_run  <= '0;
      miss_run   <= '0;
      err_run    <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (!en) begin
        state  <= StIdle;
        locked <= 1'b0;
      end else begin
        case (state)
          StIdle: begin
            state      <= StSearch;
            locked     <= 1'b0;
            slip_sel   <= '0;
            err_count  <= '0;
            word_count <= '0;
            seeded     <= 1'b0;
            match_run  <= '0;
            miss_run   <= '0;
            err_run    <= '0;
          end
          StSearch: begin
            if (rx_valid) begin
              prev <= aligned;
              if (!seeded) begin
                seeded <= 1'b1;
              end else if (match) begin
                miss_run <= '0;
                if (match_run + RUN_W'(1) == RUN_W'(LOCK_CNT)) begin
                  state     <= StLocked;
                  locked    <= 1'b1;
                  match_run <= '0;
                  err_run   <= '0;
                end else begin
                  match_run <= match_run + RUN_W'(1);
                end
              end else begin
                match_run <= '0;
                if (miss_run + RUN_W'(1) == RUN_W'(SLIP_LIM)) begin
                  // Try the next rotation and reseed from the following word.
                  slip_sel <= (slip_sel == SLIP_W'(DATA_W - 1)) ? '0 : slip_sel + SLIP_W'(1);
                  miss_run <= '0;
                  seeded   <= 1'b0;
                end else begin
                  miss_run <= miss_run + RUN_W'(1);
                end
              end
            end
          end
          StLocked: begin
            if (rx_valid) begin
              prev       <= aligned;
              word_count <= (&word_count) ? word_count : word_count + CNT_W'(1);
              if (match) begin
                err_run <= '0;
              end else begin
                err_pulse <= 1'b1;
                err_count <= (&err_count) ? err_count : err_count + CNT_W'(1);
                if (err_run + RUN_W'(1) == RUN_W'(UNLOCK_ERR)) begin
                  state     <= StSearch;
                  locked    <= 1'b0;
                  seeded    <= 1'b0;
                  match_run <= '0;
                  miss_run  <= '0;
                  err_run   <= '0;
                end else begin
                  err_run <= err_run + RUN_W'(1);
                end
              end
            end
          end
          default: begin
            state  <= StIdle;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_loopback_checker.sv
// Directed bench for loopback_checker: lock, wrap, bit-slip search, error injection,
// valid gaps, counter saturation (narrow-counter twin) and asynchronous reset.
module tb_loopback_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        locked;
  logic [2:0]  slip_sel;
  logic        err_pulse;
  logic [31:0] err_count;
  logic [31:0] word_count;

  logic        locked2;
  logic [2:0]  slip_sel2;
  logic        err_pulse2;
  logic [3:0]  err_count2;
  logic [3:0]  word_count2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  loopback_checker dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .locked     (locked),
    .slip_sel   (slip_sel),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .word_count (word_count)
  );

  // Same stimulus, 4-bit counters to exercise saturation.
  loopback_checker #(.CNT_W(4)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .locked     (locked2),
    .slip_sel   (slip_sel2),
    .err_pulse  (err_pulse2),
    .err_count  (err_count2),
    .word_count (word_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotl3(input logic [7:0] v);
    return {v[4:0], v[7:5]};
  endfunction

  initial begin
    logic [7:0] n;
    logic [7:0] c;
    int         sent;

    #12 rst = 1'b0;
    #1;
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_slip", {29'd0, slip_sel}, 32'd0);
    chk("rst_err", err_count, 32'd0);
    chk("rst_words", word_count, 32'd0);
    chk("rst_pulse", {31'd0, err_pulse}, 32'd0);

    // Aligned counting stream: seed + 16 matches locks on the 17th word.
    en = 1'b1;
    step(1'b0, 8'h00);
    n = 8'd0;
    for (int i = 0; i < 17; i++) begin
      step(1'b1, n);
      n++;
      if (i == 15) chk("lock_early", {31'd0, locked}, 32'd0);
      if (i == 16) chk("lock_17th", {31'd0, locked}, 32'd1);
    end
    for (int i = 0; i < 300; i++) begin
      step(1'b1, n);
      n++;
    end
    chk("wrap_err", err_count, 32'd0);
    chk("wrap_words", word_count, 32'd300);
    chk("sat_words", {28'd0, word_count2}, 32'd15);

    // Single corrupted word -> two errors, lock kept.
    step(1'b1, 8'h5A);
    n++;
    chk("single_pulse1", {31'd0, err_pulse}, 32'd1);
    step(1'b1, n);
    n++;
    chk("single_pulse2", {31'd0, err_pulse}, 32'd1);
    step(1'b1, n);
    n++;
    chk("single_pulse3", {31'd0, err_pulse}, 32'd0);
    chk("single_err", err_count, 32'd2);
    chk("single_locked", {31'd0, locked}, 32'd1);

    // Four bad words drop lock on the 4th; relock 17 clean words later.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h5A);
      n++;
      if (i == 2) chk("bad_still_locked", {31'd0, locked}, 32'd1);
    end
    chk("bad_unlocked", {31'd0, locked}, 32'd0);
    chk("bad_err", err_count, 32'd6);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, n);
      n++;
      if (i == 15) chk("relock_early", {31'd0, locked}, 32'd0);
    end
    chk("relock", {31'd0, locked}, 32'd1);
    chk("relock_err", err_count, 32'd6);
    chk("relock_words", word_count, 32'd307);
    chk("relock_slip", {29'd0, slip_sel}, 32'd0);

    // Random valid gaps with junk data on idle cycles.
    sent = 0;
    while (sent < 100) begin
      if ($urandom_range(1) == 1) begin
        step(1'b1, n);
        n++;
        sent++;
      end else begin
        step(1'b0, 8'hA5);
        chk("gap_pulse", {31'd0, err_pulse}, 32'd0);
      end
    end
    chk("gap_err", err_count, 32'd6);
    chk("gap_words", word_count, 32'd407);
    chk("gap_locked", {31'd0, locked}, 32'd1);
    chk("sat_err", {28'd0, err_count2}, 32'd6);

    // Asynchronous reset pulse mid-cycle while locked.
    #3 rst = 1'b1;
    #1;
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_words", word_count, 32'd0);
    chk("arst_err", err_count, 32'd0);
    #2 rst = 1'b0;

    // Rotated stream: slips 0->1->2->3 every 9 words, then locks.
    step(1'b0, 8'h00);
    c = 8'd0;
    for (int i = 0; i < 44; i++) begin
      step(1'b1, rotl3(c));
      c++;
      if (i == 7)  chk("slip_hold0", {29'd0, slip_sel}, 32'd0);
      if (i == 8)  chk("slip_to1", {29'd0, slip_sel}, 32'd1);
      if (i == 17) chk("slip_to2", {29'd0, slip_sel}, 32'd2);
      if (i == 26) chk("slip_to3", {29'd0, slip_sel}, 32'd3);
      if (i == 42) chk("rot_lock_early", {31'd0, locked}, 32'd0);
    end
    chk("rot_locked", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, rotl3(c));
      c++;
    end
    chk("rot_err", err_count, 32'd0);
    chk("rot_words", word_count, 32'd10);
    chk("rot_slip", {29'd0, slip_sel}, 32'd3);

    // en low: IDLE, counters hold.
    en = 1'b0;
    step(1'b1, rotl3(c));
    chk("idle_locked", {31'd0, locked}, 32'd0);
    step(1'b1, 8'h00);
    chk("idle_words", word_count, 32'd10);
    chk("idle_slip", {29'd0, slip_sel}, 32'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
